// File: rtl/pc_fetch_if.sv
// Fetch/execute bus between the sequencer, its controller and the program ROM.
interface pc_fetch_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic                  en;
  logic                  pc_inc;
  logic                  pc_load;
  logic [ADDR_W-1:0]     load_addr;
  logic [DATA_W-1:0]     rom_data;
  logic [ADDR_W-1:0]     pc_addr;
  logic [DATA_W/2-1:0]   instr;
  logic [DATA_W/2-1:0]   oprnd;
  logic                  phase;
  logic                  fetch_valid;

  modport master (
    output en, pc_inc, pc_load, load_addr, rom_data,
    input  pc_addr, instr, oprnd, phase, fetch_valid
  );

  modport slave (
    input  en, pc_inc, pc_load, load_addr, rom_data,
    output pc_addr, instr, oprnd, phase, fetch_valid
  );
endinterface

// File: rtl/pc_fetch.sv
// Two-phase program counter: FETCH latches the ROM word, EXECUTE advances or loads the PC.
module pc_fetch #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  pc_fetch_if.slave  bus
);
  localparam int HALF_W = DATA_W / 2;

  localparam logic [0:0] FETCH   = 1'b0;
  localparam logic [0:0] EXECUTE = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [HALF_W-1:0] instr_q;
  logic [HALF_W-1:0] oprnd_q;
  logic              fetch_valid_q;

  // Increment wraps modulo 2^ADDR_W with no carry out.
  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] cur);
    return cur + ADDR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= FETCH;
      pc            <= '0;
      instr_q       <= '0;
      oprnd_q       <= '0;
      fetch_valid_q <= 1'b0;
    end else if (bus.en) begin
      if (state == FETCH) begin
        instr_q       <= bus.rom_data[DATA_W-1:HALF_W];
        oprnd_q       <= bus.rom_data[HALF_W-1:0];
        fetch_valid_q <= 1'b1;
        state         <= EXECUTE;
      end else begin
        // Load outranks increment; requests only count in this phase.
        if (bus.pc_load)
          pc <= bus.load_addr;
        else if (bus.pc_inc)
          pc <= next_pc(pc);
        fetch_valid_q <= 1'b0;
        state         <= FETCH;
      end
    end
  end

  assign bus.pc_addr     = pc;
  assign bus.instr       = instr_q;
  assign bus.oprnd       = oprnd_q;
  assign bus.phase       = state[0];
  assign bus.fetch_valid = fetch_valid_q;
endmodule

// File: tb/tb_pc_fetch.sv
// Vector table with expected outputs queued per drive and popped after each edge.
module tb_pc_fetch;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;

  typedef struct {
    string            name;
    logic             rst;
    logic             en;
    logic             inc;
    logic             ld;
    logic [ADDR_W-1:0] la;
    logic [ADDR_W-1:0] pc;
    logic [3:0]       ins;
    logic [3:0]       opr;
    logic             ph;
    logic             fv;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic [DATA_W-1:0] rom [0:(1<<ADDR_W)-1];

  pc_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  pc_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.rom_data = rom[bus.pc_addr];

  always #5 clk = ~clk;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(string name, logic rst, logic en, logic inc, logic ld,
                              logic [ADDR_W-1:0] la, logic [ADDR_W-1:0] pc,
                              logic [3:0] ins, logic [3:0] opr, logic ph, logic fv);
    vec_t v;
    v.name = name; v.rst = rst; v.en = en; v.inc = inc; v.ld = ld; v.la = la;
    v.pc = pc; v.ins = ins; v.opr = opr; v.ph = ph; v.fv = fv;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    reset       = v.rst;
    bus.en      = v.en;
    bus.pc_inc  = v.inc;
    bus.pc_load = v.ld;
    bus.load_addr = v.la;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n_vec++;
    if (bus.pc_addr !== e.pc || bus.instr !== e.ins || bus.oprnd !== e.opr ||
        bus.phase !== e.ph || bus.fetch_valid !== e.fv) begin
      n_err++;
      $display("FAIL %s: got pc=%h instr=%h oprnd=%h phase=%b fv=%b, want pc=%h instr=%h oprnd=%h phase=%b fv=%b",
               e.name, bus.pc_addr, bus.instr, bus.oprnd, bus.phase, bus.fetch_valid,
               e.pc, e.ins, e.opr, e.ph, e.fv);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = 8'hE1;
    rom[12'h000] = 8'h3A;
    rom[12'h001] = 8'h5C;
    rom[12'h123] = 8'h7E;
    rom[12'hFFF] = 8'hD4;
    rom[12'h040] = 8'h99;

    reset = 1'b1; bus.en = 1'b0; bus.pc_inc = 1'b0; bus.pc_load = 1'b0; bus.load_addr = '0;

    //             name          rst en inc ld la      pc      ins   opr   ph fv
    tbl.push_back(mk("reset",     1, 1, 1, 1, 12'h7AB, 12'h000, 4'h0, 4'h0, 0, 0));
    tbl.push_back(mk("fetch0",    0, 1, 1, 0, 12'h000, 12'h000, 4'h3, 4'hA, 1, 1));
    tbl.push_back(mk("exec_inc0", 0, 1, 1, 0, 12'h000, 12'h001, 4'h3, 4'hA, 0, 0));
    tbl.push_back(mk("fetch1",    0, 1, 1, 0, 12'h000, 12'h001, 4'h5, 4'hC, 1, 1));
    tbl.push_back(mk("load_wins", 0, 1, 1, 1, 12'h123, 12'h123, 4'h5, 4'hC, 0, 0));
    tbl.push_back(mk("fetch123",  0, 1, 0, 0, 12'h000, 12'h123, 4'h7, 4'hE, 1, 1));
    tbl.push_back(mk("load_fff",  0, 1, 0, 1, 12'hFFF, 12'hFFF, 4'h7, 4'hE, 0, 0));
    tbl.push_back(mk("fetchfff",  0, 1, 1, 0, 12'h000, 12'hFFF, 4'hD, 4'h4, 1, 1));
    tbl.push_back(mk("wrap",      0, 1, 1, 0, 12'h000, 12'h000, 4'hD, 4'h4, 0, 0));
    tbl.push_back(mk("ld_in_fet", 0, 1, 0, 1, 12'h040, 12'h000, 4'h3, 4'hA, 1, 1));
    tbl.push_back(mk("no_memory", 0, 1, 1, 0, 12'h040, 12'h001, 4'h3, 4'hA, 0, 0));
    tbl.push_back(mk("en0_fetch", 0, 0, 0, 1, 12'h040, 12'h001, 4'h3, 4'hA, 0, 0));
    tbl.push_back(mk("fetch1b",   0, 1, 1, 0, 12'h000, 12'h001, 4'h5, 4'hC, 1, 1));
    foreach (tbl[i]) apply(tbl[i]);

    // Stall mid-EXECUTE with increment held: frozen, then exactly one step.
    for (int k = 0; k < 4; k++)
      apply(mk("stall", 0, 0, 1, 0, 12'h000, 12'h001, 4'h5, 4'hC, 1, 1));
    apply(mk("resume_inc", 0, 1, 1, 0, 12'h000, 12'h002, 4'h5, 4'hC, 0, 0));
    apply(mk("fetch2",     0, 1, 1, 0, 12'h000, 12'h002, 4'hE, 4'h1, 1, 1));
    apply(mk("exec2",      0, 1, 1, 0, 12'h000, 12'h003, 4'hE, 4'h1, 0, 0));
    apply(mk("fetch3",     0, 1, 1, 0, 12'h000, 12'h003, 4'hE, 4'h1, 1, 1));

    // Reset during EXECUTE with a pending load aborts the load.
    apply(mk("rst_exec",   1, 1, 0, 1, 12'h200, 12'h000, 4'h0, 4'h0, 0, 0));
    apply(mk("post_rst_f", 0, 1, 0, 0, 12'h200, 12'h000, 4'h3, 4'hA, 1, 1));
    apply(mk("post_rst_x", 0, 1, 0, 0, 12'h200, 12'h000, 4'h3, 4'hA, 0, 0));
    apply(mk("fetch0b",    0, 1, 0, 0, 12'h000, 12'h000, 4'h3, 4'hA, 1, 1));
    apply(mk("rst_over_en",1, 0, 1, 1, 12'h555, 12'h000, 4'h0, 4'h0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
